// File: rtl/uart_buffered.sv
// Memory-mapped UART with TX/RX byte FIFOs, runtime baud divisor, optional parity,
// 1/2 stop bits, sticky W1C error flags and internal loopback.
module uart_buffered #(
  parameter int CLOCK_HZ      = 50000000,
  parameter int DEFAULT_BAUD  = 115200,
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        tx_pin,
  input  logic        rx_pin,
  input  logic        write_en,
  input  logic        read_en,
  input  logic [1:0]  addr,
  input  logic [31:0] write_val,
  output logic [31:0] read_val,
  output logic [6:0]  uart_status
);

  localparam int TXD = 1 << TX_DEPTH_LOG2;
  localparam int RXD = 1 << RX_DEPTH_LOG2;
  localparam logic [15:0] BAUD_RST = 16'(CLOCK_HZ / DEFAULT_BAUD);
  localparam logic [TX_DEPTH_LOG2:0] TX_ONE  = 1;
  localparam logic [RX_DEPTH_LOG2:0] RX_ONE  = 1;
  localparam logic [TX_DEPTH_LOG2:0] TX_FULL = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
  localparam logic [RX_DEPTH_LOG2:0] RX_FULL = {1'b1, {RX_DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  logic [4:0]  ctrl_q;
  logic [15:0] baud_q;
  logic [2:0]  err_q, err_d;
  logic [31:0] read_val_q, rd_mux;
  logic [6:0]  status;

  logic [7:0] tx_mem_q [TXD];
  logic [7:0] rx_mem_q [RXD];
  logic [TX_DEPTH_LOG2:0] tx_wp_q, tx_rp_q;
  logic [RX_DEPTH_LOG2:0] rx_wp_q, rx_rp_q;
  logic tx_empty, tx_full, tx_push, tx_pop, rx_empty, rx_full, rx_push, rx_pop;
  logic [7:0] tx_head, rx_head;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d, tx_two_stop_q, tx_two_stop_d;
  logic        tx_q, tx_d, tx_load, tx_tick;

  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d, rx_par_bit_q, rx_par_bit_d;
  logic        rx_prev_q, rx_src, rx_tick, rx_good, rx_ferr, rx_perr, rx_ovf;
  logic        wr_data, wr_stat, wr_ctrl, wr_baud;
  logic        unused_bits;

  assign unused_bits = ^write_val[31:16];

  assign wr_data = write_en && (addr == 2'd0);
  assign wr_stat = write_en && (addr == 2'd1);
  assign wr_ctrl = write_en && (addr == 2'd2);
  assign wr_baud = write_en && (addr == 2'd3);

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = ((tx_wp_q ^ tx_rp_q) == TX_FULL);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = ((rx_wp_q ^ rx_rp_q) == RX_FULL);
  assign tx_head  = tx_mem_q[tx_rp_q[TX_DEPTH_LOG2-1:0]];
  assign rx_head  = rx_mem_q[rx_rp_q[RX_DEPTH_LOG2-1:0]];
  assign tx_push  = wr_data && !tx_full;
  assign tx_pop   = tx_load;
  assign rx_pop   = read_en && (addr == 2'd0) && !rx_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign rx_push  = rx_good && (!rx_full || rx_pop);
  assign rx_ovf   = rx_good && rx_full && !rx_pop;

  assign tx_tick = (tx_cnt_q == 16'd0);
  assign rx_tick = (rx_cnt_q == 16'd0);
  assign rx_src  = ctrl_q[4] ? tx_q : rx_pin;

  assign status      = {err_q, !rx_empty, ctrl_q[0], !tx_full, tx_empty && (tx_state_q == TX_IDLE)};
  assign uart_status = status;
  assign read_val    = read_val_q;
  assign tx_pin      = tx_q;
  assign err_d       = (err_q & ~(wr_stat ? write_val[6:4] : 3'b000)) | {rx_ovf, rx_perr, rx_ferr};

  always_comb begin
    rd_mux = 32'd0;
    case (addr)
      2'd0: rd_mux = rx_empty ? 32'd0 : {24'd0, rx_head};
      2'd1: rd_mux = {25'd0, status};
      2'd2: rd_mux = {27'd0, ctrl_q};
      2'd3: rd_mux = {16'd0, baud_q};
      default: rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    tx_state_d    = tx_state_q;
    tx_cnt_d      = tx_cnt_q - 16'd1;
    tx_bit_d      = tx_bit_q;
    tx_shift_d    = tx_shift_q;
    tx_div_d      = tx_div_q;
    tx_par_d      = tx_par_q;
    tx_par_en_d   = tx_par_en_q;
    tx_two_stop_d = tx_two_stop_q;
    tx_d          = tx_q;
    tx_load       = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = tx_cnt_q;
        tx_load  = !tx_empty;
      end
      TX_START: if (tx_tick) begin
        tx_state_d = TX_DATA;
        tx_cnt_d   = tx_div_q - 16'd1;
        tx_bit_d   = 3'd0;
        tx_d       = tx_shift_q[0];
      end
      TX_DATA: if (tx_tick) begin
        tx_cnt_d = tx_div_q - 16'd1;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP1;
          tx_d       = tx_par_en_q ? tx_par_q : 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_d       = tx_shift_q[1];
        end
      end
      TX_PARITY: if (tx_tick) begin
        tx_state_d = TX_STOP1;
        tx_cnt_d   = tx_div_q - 16'd1;
        tx_d       = 1'b1;
      end
      TX_STOP1: if (tx_tick) begin
        tx_cnt_d = tx_div_q - 16'd1;
        if (tx_two_stop_q) tx_state_d = TX_STOP2;
        else begin
          tx_state_d = TX_IDLE;
          tx_load    = !tx_empty;
        end
      end
      TX_STOP2: if (tx_tick) begin
        tx_state_d = TX_IDLE;
        tx_load    = !tx_empty;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Frame start: pop, and freeze divisor and framing for the whole frame.
    if (tx_load) begin
      tx_state_d    = TX_START;
      tx_cnt_d      = baud_q - 16'd1;
      tx_div_d      = baud_q;
      tx_shift_d    = tx_head;
      tx_par_d      = (^tx_head) ^ ctrl_q[2];
      tx_par_en_d   = ctrl_q[1];
      tx_two_stop_d = ctrl_q[3];
      tx_d          = 1'b0;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q - 16'd1;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_div_d     = rx_div_q;
    rx_par_en_d  = rx_par_en_q;
    rx_par_odd_d = rx_par_odd_q;
    rx_par_bit_d = rx_par_bit_q;
    rx_good      = 1'b0;
    rx_ferr      = 1'b0;
    rx_perr      = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = rx_cnt_q;
        if (rx_prev_q && !rx_src) begin
          rx_state_d   = RX_START;
          rx_cnt_d     = {1'b0, baud_q[15:1]} - 16'd1;
          rx_div_d     = baud_q;
          rx_par_en_d  = ctrl_q[1];
          rx_par_odd_d = ctrl_q[2];
        end
      end
      RX_START: if (rx_tick) begin
        rx_cnt_d   = rx_div_q - 16'd1;
        rx_bit_d   = 3'd0;
        rx_state_d = rx_src ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_tick) begin
        rx_cnt_d   = rx_div_q - 16'd1;
        rx_shift_d = {rx_src, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end
      RX_PARITY: if (rx_tick) begin
        rx_cnt_d     = rx_div_q - 16'd1;
        rx_par_bit_d = rx_src;
        rx_state_d   = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        rx_state_d = RX_IDLE;
        if (!rx_src) rx_ferr = 1'b1;
        else if (rx_par_en_q && (rx_par_bit_q != ((^rx_shift_q) ^ rx_par_odd_q))) rx_perr = 1'b1;
        else rx_good = 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (!ctrl_q[0]) begin
      rx_state_d = RX_IDLE;
      rx_good    = 1'b0;
      rx_ferr    = 1'b0;
      rx_perr    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q[TX_DEPTH_LOG2-1:0]] <= write_val[7:0];
    if (rx_push) rx_mem_q[rx_wp_q[RX_DEPTH_LOG2-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0; baud_q <= BAUD_RST; err_q <= '0; read_val_q <= '0;
      tx_wp_q <= '0; tx_rp_q <= '0; rx_wp_q <= '0; rx_rp_q <= '0;
      tx_state_q <= TX_IDLE; tx_cnt_q <= '0; tx_bit_q <= '0; tx_shift_q <= '0; tx_div_q <= BAUD_RST;
      tx_par_q <= 1'b0; tx_par_en_q <= 1'b0; tx_two_stop_q <= 1'b0; tx_q <= 1'b1;
      rx_state_q <= RX_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0; rx_shift_q <= '0; rx_div_q <= BAUD_RST;
      rx_par_en_q <= 1'b0; rx_par_odd_q <= 1'b0; rx_par_bit_q <= 1'b0; rx_prev_q <= 1'b1;
    end else begin
      if (wr_ctrl) ctrl_q <= write_val[4:0];
      if (wr_baud) baud_q <= (write_val[15:0] < 16'd4) ? 16'd4 : write_val[15:0];
      err_q <= err_d;
      if (read_en) read_val_q <= rd_mux;
      if (tx_push) tx_wp_q <= tx_wp_q + TX_ONE;
      if (tx_pop)  tx_rp_q <= tx_rp_q + TX_ONE;
      if (rx_push) rx_wp_q <= rx_wp_q + RX_ONE;
      if (rx_pop)  rx_rp_q <= rx_rp_q + RX_ONE;
      tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d; tx_shift_q <= tx_shift_d;
      tx_div_q <= tx_div_d; tx_par_q <= tx_par_d; tx_par_en_q <= tx_par_en_d;
      tx_two_stop_q <= tx_two_stop_d; tx_q <= tx_d;
      rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d; rx_shift_q <= rx_shift_d;
      rx_div_q <= rx_div_d; rx_par_en_q <= rx_par_en_d; rx_par_odd_q <= rx_par_odd_d;
      rx_par_bit_q <= rx_par_bit_d; rx_prev_q <= rx_src;
    end
  end

endmodule

// File: tb/tb_uart_buffered.sv
// Bench for uart_buffered: randomized frames checked against a bit-list / queue reference model.
module tb_uart_buffered;
  logic        clk = 1'b0;
  logic        rst, tx_pin, rx_pin, write_en, read_en;
  logic [1:0]  addr;
  logic [31:0] write_val, read_val;
  logic [6:0]  uart_status;
  int checks = 0;
  int errors = 0;

  uart_buffered dut (
    .clk(clk), .rst(rst), .tx_pin(tx_pin), .rx_pin(rx_pin), .write_en(write_en),
    .read_en(read_en), .addr(addr), .write_val(write_val), .read_val(read_val),
    .uart_status(uart_status)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; write_en = 1'b0; read_en = 1'b0; addr = 2'd0; write_val = '0; rx_pin = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
    addr = a; write_val = v; write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
    addr = a; read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    v = read_val;
  endtask

  // Drives one serial frame on rx_pin; optionally pulses a DATA read at slot pop_slot.
  task automatic drive_frame(input logic [7:0] b, input int d, input bit use_par, input bit par_bit,
                             input bit stop_bit, input int pop_slot, output logic [31:0] popped);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (use_par) bits.push_back(par_bit);
    bits.push_back(stop_bit);
    popped = '0;
    for (int s = 0; s < bits.size() * d; s++) begin
      rx_pin = bits[s / d];
      if (s == pop_slot) begin addr = 2'd0; read_en = 1'b1; end
      else read_en = 1'b0;
      @(negedge clk);
      if (s == pop_slot) popped = read_val;
    end
    read_en = 1'b0;
    rx_pin = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL reset_tx_pin: got %b want 1", tx_pin); end
    checks++; if (uart_status !== 7'h03) begin errors++; $display("FAIL reset_status: got %0h want 03", uart_status); end
    checks++; if (read_val !== 32'd0) begin errors++; $display("FAIL reset_read_val: got %0h want 0", read_val); end
    bus_read(2'd3, v);
    checks++; if (v !== 32'd434) begin errors++; $display("FAIL reset_baud: got %0d want 434", v); end
    bus_read(2'd2, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_control: got %0h want 0", v); end
    bus_read(2'd0, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_data_empty: got %0h want 0", v); end
  endtask

  task automatic test_baud_clamp();
    logic [31:0] v;
    logic [31:0] w;
    w = $urandom_range(0, 3);
    bus_write(2'd3, w);
    bus_read(2'd3, v);
    checks++; if (v !== 32'd4) begin errors++; $display("FAIL baud_clamp: wrote %0d got %0d want 4", w, v); end
    w = $urandom_range(4, 65535) | 32'hABCD_0000;
    bus_write(2'd3, w);
    bus_read(2'd3, v);
    checks++; if (v !== {16'd0, w[15:0]}) begin errors++; $display("FAIL baud_rw: got %0h want %0h", v, w[15:0]); end
  endtask

  task automatic test_tx_frame();
    for (int t = 0; t < 4; t++) begin
      int d, n;
      logic [7:0] b;
      logic [2:0] cfg;
      bit exp_bits[$];
      bit ok;
      do_reset();
      if (t == 0) begin d = 8; b = 8'hA5; cfg = 3'b000; end
      else begin d = $urandom_range(4, 12); b = 8'($urandom); cfg = 3'($urandom); end
      bus_write(2'd3, d);
      bus_write(2'd2, {28'd0, cfg, 1'b0});
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
      if (cfg[0]) exp_bits.push_back((^b) ^ cfg[1]);
      exp_bits.push_back(1'b1);
      if (cfg[2]) exp_bits.push_back(1'b1);
      bus_write(2'd0, {24'd0, b});
      n = 0;
      while (tx_pin !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (tx_pin !== 1'b0) begin errors++; $display("FAIL tx_start_timeout: tx_pin=%b want 0", tx_pin); continue; end
      for (int i = 0; i < exp_bits.size(); i++) begin
        ok = 1'b1;
        for (int c = 0; c < d; c++) begin
          if (tx_pin !== exp_bits[i]) ok = 1'b0;
          @(negedge clk);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL tx_bit: frame %0d byte %0h bit %0d not held at %b for %0d clk", t, b, i, exp_bits[i], d); end
      end
      checks++;
      if (uart_status[0] !== 1'b1) begin errors++; $display("FAIL tx_idle_after: got %b want 1", uart_status[0]); end
    end
  endtask

  task automatic test_loopback();
    logic [7:0] rxq[$];
    logic [31:0] v;
    logic [7:0] b;
    int occ, n, d;
    do_reset();
    d = $urandom_range(4, 5);
    bus_write(2'd3, d);
    bus_write(2'd2, 32'h11);
    b = 8'($urandom);
    bus_write(2'd0, {24'd0, b});
    rxq.push_back(b);
    n = 0;
    while (tx_pin !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    occ = 0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      bus_write(2'd0, {24'd0, b});
      if (occ < 16) begin occ++; rxq.push_back(b); end
      if (i == 15) begin
        checks++;
        if (uart_status[1] !== 1'b0) begin errors++; $display("FAIL tx_full_flag: tx_not_full=%b want 0", uart_status[1]); end
      end
    end
    n = 0;
    while (uart_status[3] !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    bus_read(2'd0, v);
    b = rxq.pop_front();
    checks++; if (v !== {24'd0, b}) begin errors++; $display("FAIL loop_first: got %0h want %0h", v, b); end
    n = 0;
    while (uart_status[0] !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    wait_cycles(4 * d);
    checks++; if (uart_status[6] !== 1'b0) begin errors++; $display("FAIL loop_overrun: got %b want 0", uart_status[6]); end
    for (int i = 0; i < 16; i++) begin
      bus_read(2'd0, v);
      b = rxq.pop_front();
      checks++; if (v !== {24'd0, b}) begin errors++; $display("FAIL loop_data: read %0d got %0h want %0h", i, v, b); end
    end
    bus_read(2'd0, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL loop_empty_read: got %0h want 0", v); end
  endtask

  task automatic test_parity();
    logic [31:0] v, p;
    logic [7:0] b;
    bit odd, good;
    do_reset();
    bus_write(2'd3, 32'd8);
    bus_write(2'd2, 32'h07);
    drive_frame(8'h03, 8, 1'b1, 1'b0, 1'b1, -1, p);
    wait_cycles(4);
    checks++; if (uart_status[5] !== 1'b1) begin errors++; $display("FAIL parity_err_set: got %b want 1", uart_status[5]); end
    checks++; if (uart_status[3] !== 1'b0) begin errors++; $display("FAIL parity_discard: rx_avail=%b want 0", uart_status[3]); end
    bus_write(2'd1, 32'h20);
    checks++; if (uart_status[5] !== 1'b0) begin errors++; $display("FAIL parity_clear: got %b want 0", uart_status[5]); end
    for (int t = 0; t < 4; t++) begin
      b = 8'($urandom); odd = 1'($urandom); good = (t % 2 == 0);
      bus_write(2'd2, {27'd0, 2'b00, odd, 2'b11});
      drive_frame(b, 8, 1'b1, (^b) ^ odd ^ !good, 1'b1, -1, p);
      wait_cycles(4);
      if (good) begin
        checks++; if (uart_status[5] !== 1'b0) begin errors++; $display("FAIL parity_good_flag: b=%0h odd=%b perr=%b want 0", b, odd, uart_status[5]); end
        bus_read(2'd0, v);
        checks++; if (v !== {24'd0, b}) begin errors++; $display("FAIL parity_good_data: got %0h want %0h", v, b); end
      end else begin
        checks++; if (uart_status[5:3] !== 3'b100) begin errors++; $display("FAIL parity_bad: b=%0h odd=%b status[5:3]=%b want 100", b, odd, uart_status[5:3]); end
        bus_write(2'd1, 32'h20);
      end
    end
  endtask

  task automatic test_frame_err();
    logic [31:0] v, p;
    logic [7:0] b;
    do_reset();
    bus_write(2'd3, 32'd8);
    bus_write(2'd2, 32'h01);
    drive_frame(8'($urandom), 8, 1'b0, 1'b0, 1'b0, -1, p);
    wait_cycles(4);
    checks++; if (uart_status[4:3] !== 2'b10) begin errors++; $display("FAIL frame_err: status[4:3]=%b want 10", uart_status[4:3]); end
    bus_write(2'd1, 32'h10);
    checks++; if (uart_status[4] !== 1'b0) begin errors++; $display("FAIL frame_clear: got %b want 0", uart_status[4]); end
    rx_pin = 1'b0;
    @(negedge clk);
    rx_pin = 1'b1;
    wait_cycles(30);
    checks++; if (uart_status[6:3] !== 4'b0000) begin errors++; $display("FAIL glitch: status[6:3]=%b want 0000", uart_status[6:3]); end
    b = 8'($urandom);
    drive_frame(b, 8, 1'b0, 1'b0, 1'b1, -1, p);
    wait_cycles(2);
    bus_read(2'd0, v);
    checks++; if (v !== {24'd0, b}) begin errors++; $display("FAIL recover_data: got %0h want %0h", v, b); end
  endtask

  task automatic test_overrun();
    logic [7:0] q[$];
    logic [31:0] v, p;
    logic [7:0] b, h;
    do_reset();
    bus_write(2'd3, 32'd4);
    bus_write(2'd2, 32'h01);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      drive_frame(b, 4, 1'b0, 1'b0, 1'b1, -1, p);
      q.push_back(b);
    end
    wait_cycles(2);
    checks++; if (uart_status[6] !== 1'b0) begin errors++; $display("FAIL fill_no_overrun: got %b want 0", uart_status[6]); end
    drive_frame(8'($urandom), 4, 1'b0, 1'b0, 1'b1, -1, p);
    wait_cycles(2);
    checks++; if (uart_status[6] !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", uart_status[6]); end
    bus_write(2'd1, 32'h40);
    checks++; if (uart_status[6] !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", uart_status[6]); end
    // Stop bit is sampled half a bit plus nine bits after the start edge: slot 2 + 36.
    b = 8'($urandom);
    drive_frame(b, 4, 1'b0, 1'b0, 1'b1, 38, p);
    h = q.pop_front();
    q.push_back(b);
    checks++; if (p !== {24'd0, h}) begin errors++; $display("FAIL overrun_head: got %0h want %0h", p, h); end
    wait_cycles(2);
    checks++; if (uart_status[6] !== 1'b0) begin errors++; $display("FAIL coincident_pop: overrun=%b want 0", uart_status[6]); end
    for (int i = 0; i < 16; i++) begin
      bus_read(2'd0, v);
      h = q.pop_front();
      checks++; if (v !== {24'd0, h}) begin errors++; $display("FAIL drain: read %0d got %0h want %0h", i, v, h); end
    end
    bus_read(2'd0, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL drain_empty: got %0h want 0", v); end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] v;
    int n;
    bit ok;
    do_reset();
    bus_write(2'd3, 32'd8);
    bus_write(2'd2, 32'h01);
    bus_write(2'd0, 32'h5A);
    bus_write(2'd0, 32'hC3);
    n = 0;
    while (tx_pin !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    wait_cycles(20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL rst_mid_tx_pin: got %b want 1", tx_pin); end
    checks++; if (uart_status !== 7'h03) begin errors++; $display("FAIL rst_mid_status: got %0h want 03", uart_status); end
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (tx_pin !== 1'b1 || uart_status[0] !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_fifo_empty: tx activity after reset, tx_pin=%b", tx_pin); end
    bus_read(2'd3, v);
    checks++; if (v !== 32'd434) begin errors++; $display("FAIL rst_mid_baud: got %0d want 434", v); end
  endtask

  initial begin
    test_reset();
    test_baud_clamp();
    test_tx_frame();
    test_loopback();
    test_parity();
    test_frame_err();
    test_overrun();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
